// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator: prescaler with square-wave output,
// oversample counter, bit-rate and mid-bit strobes, and start-bit phase realign.
module baud_tick_gen #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 5200,
  parameter int unsigned OS_RATIO    = 16,
  parameter int unsigned OS_W        = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             sync,
  output logic [CNT_W-1:0] div_q,
  output logic             clk_div,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_DEFAULT);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OS_RATIO - 1);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OS_RATIO / 2 - 1);

  if (OS_RATIO < 2 || OS_RATIO > 256 || (OS_RATIO % 2) != 0 ||
      (64'd1 << OS_W) < 64'(OS_RATIO)) begin : g_bad_params
    $error("baud_tick_gen: OS_RATIO must be even, 2..256, and fit in OS_W bits");
  end

  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] divisor_q, divisor_d;
  logic [OS_W-1:0]  os_cnt_q,  os_cnt_d;
  logic             clk_div_q,  clk_div_d;
  logic             os_tick_q,  os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             load_err_q, load_err_d;

  logic load_ok;
  logic load_bad;
  logic terminal;

  assign load_ok  = load && (div_value != '0);
  assign load_bad = load && (div_value == '0);
  assign terminal = (count_q == divisor_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    count_d    = count_q;
    divisor_d  = divisor_q;
    os_cnt_d   = os_cnt_q;
    clk_div_d  = clk_div_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    load_err_d = load_err_q;

    // A load is accepted (or flagged) regardless of sync or enable.
    if (load_ok) begin
      divisor_d = div_value;
    end
    if (load_bad) begin
      load_err_d = 1'b1;
    end

    if (sync) begin
      count_d  = '0;
      os_cnt_d = '0;
    end else if (load_ok) begin
      count_d = '0;
    end else if (enable) begin
      if (terminal) begin
        count_d    = '0;
        clk_div_d  = ~clk_div_q;
        os_tick_d  = 1'b1;
        mid_tick_d = (os_cnt_q == OS_MID);
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d   = '0;
          bit_tick_d = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      divisor_q  <= DIV_RESET;
      os_cnt_q   <= '0;
      clk_div_q  <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      divisor_q  <= divisor_d;
      os_cnt_q   <= os_cnt_d;
      clk_div_q  <= clk_div_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign div_q    = divisor_q;
  assign clk_div  = clk_div_q;
  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen: cadence, sync, load, enable
// and asynchronous reset, with cycle counts taken on the falling clock edge.
module tb_baud_tick_gen;

  localparam int CNT_W = 32;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             enable;
  logic             load;
  logic [CNT_W-1:0] div_value;
  logic             sync;
  logic [CNT_W-1:0] div_q;
  logic             clk_div;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic             load_err;

  int n_cmp = 0;
  int n_err = 0;

  baud_tick_gen #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(5200),
    .OS_RATIO   (16),
    .OS_W       (8)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .div_value(div_value),
    .sync     (sync),
    .div_q    (div_q),
    .clk_div  (clk_div),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .load_err (load_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return os_tick;
      1:       return bit_tick;
      2:       return mid_tick;
      default: return clk_div;
    endcase
  endfunction

  // Falling edges until the selected output is high; -1 if the budget runs out.
  task automatic wait_for(input int sel, input int budget, output int n);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_in);
      if (sig(sel)) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  // Falling edges for which clk_div stays at lvl, starting at the current one.
  task automatic level_len(input logic lvl, input int budget, output int n);
    n = 0;
    while (clk_div == lvl && n < budget) begin
      n++;
      @(negedge clk_in);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, viol, toggles, oss;
    logic cd, prev;
    int os_q[$], bit_q[$], mid_q[$], rise_q[$];

    reset = 1'b0; enable = 1'b0; load = 1'b0; sync = 1'b0; div_value = '0;
    #7;
    check("rst_div_q", div_q, 5200);
    check("rst_clk_div", clk_div, 0);
    check("rst_strobes", {os_tick, bit_tick, mid_tick}, 0);
    check("rst_load_err", load_err, 0);

    // Default divisor straight out of reset.
    @(negedge clk_in);
    reset = 1'b1; enable = 1'b1;
    wait_for(0, 6000, n);
    check("def_first_os", n, 5201);
    level_len(1'b1, 6000, n);
    check("def_clk_high", n, 5201);
    level_len(1'b0, 6000, n);
    check("def_clk_low", n, 5201);

    // Fresh start with divisor 3.
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1; load = 1'b1; div_value = 3;
    @(negedge clk_in);
    load = 1'b0;
    check("ld3_div_q", div_q, 3);
    viol = 0;
    prev = clk_div;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk_in);
      if (os_tick) os_q.push_back(i);
      if (bit_tick) bit_q.push_back(i);
      if (mid_tick) mid_q.push_back(i);
      if (clk_div && !prev) rise_q.push_back(i);
      prev = clk_div;
      if ((bit_tick && mid_tick) || ((bit_tick || mid_tick) && !os_tick)) viol++;
    end
    check("ld3_os_first", os_q.size() > 1 ? os_q[0] : -1, 4);
    check("ld3_os_period", os_q.size() > 1 ? os_q[1] - os_q[0] : -1, 4);
    check("ld3_clk_period", rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1, 8);
    check("ld3_mid0", mid_q.size() > 1 ? mid_q[0] : -1, 32);
    check("ld3_bit0", bit_q.size() > 1 ? bit_q[0] : -1, 64);
    check("ld3_bit_period", bit_q.size() > 1 ? bit_q[1] - bit_q[0] : -1, 64);
    check("ld3_mid_after_bit", mid_q.size() > 1 && bit_q.size() > 0 ? mid_q[1] - bit_q[0] : -1, 32);
    check("ld3_strobe_rules", viol, 0);

    // Sync at count=2, os_cnt=5.
    sync = 1'b1;
    @(negedge clk_in);
    sync = 1'b0;
    repeat (22) @(negedge clk_in);
    sync = 1'b1;
    @(negedge clk_in);
    sync = 1'b0;
    check("sync_no_strobe", {os_tick, bit_tick, mid_tick}, 0);
    wait_for(0, 10, n);
    check("sync_next_os", n, 4);
    wait_for(2, 40, n2);
    check("sync_first_mid", (n < 0 || n2 < 0) ? -1 : n + n2, 32);

    // Sync landing on a terminal count suppresses it.
    repeat (3) @(negedge clk_in);
    sync = 1'b1;
    cd = clk_div;
    @(negedge clk_in);
    sync = 1'b0;
    check("sync_tc_no_os", os_tick, 0);
    check("sync_tc_clk_hold", clk_div, cd);
    wait_for(0, 10, n);
    check("sync_tc_next_os", n, 4);

    // Rejected zero load, then a load of 7.
    load = 1'b1; div_value = 0;
    @(negedge clk_in);
    load = 1'b0;
    check("ld0_err", load_err, 1);
    check("ld0_div_q", div_q, 3);
    wait_for(0, 10, n);
    check("ld0_os_cadence", n, 3);
    wait_for(0, 10, n);
    check("ld0_os_period", n, 4);
    load = 1'b1; div_value = 7;
    @(negedge clk_in);
    load = 1'b0;
    check("ld7_div_q", div_q, 7);
    check("ld7_no_os", os_tick, 0);
    wait_for(0, 20, n);
    check("ld7_first_os", n, 8);
    wait_for(0, 20, n);
    check("ld7_os_period", n, 8);
    check("ld7_err_sticky", load_err, 1);

    // Enable low for 10 cycles mid-count.
    repeat (3) @(negedge clk_in);
    enable = 1'b0;
    cd = clk_div;
    viol = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (os_tick || bit_tick || mid_tick || clk_div != cd) viol++;
    end
    check("en0_frozen", viol, 0);
    enable = 1'b1;
    wait_for(0, 20, n);
    check("en0_resume_os", n, 5);

    // Minimum divisor of 1.
    load = 1'b1; div_value = 1;
    @(negedge clk_in);
    load = 1'b0;
    check("ld1_div_q", div_q, 1);
    toggles = 0; oss = 0;
    prev = clk_div;
    repeat (8) begin
      @(negedge clk_in);
      if (clk_div != prev) toggles++;
      prev = clk_div;
      if (os_tick) oss++;
    end
    check("ld1_os_count", oss, 4);
    check("ld1_clk_toggles", toggles, 4);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0;
    #1;
    check("arst_div_q", div_q, 5200);
    check("arst_outputs", {clk_div, os_tick, bit_tick, mid_tick, load_err}, 0);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (5) @(negedge clk_in);
    sync = 1'b1; load = 1'b1; div_value = 2;
    @(negedge clk_in);
    sync = 1'b0; load = 1'b0;
    check("sl_div_q", div_q, 2);
    check("sl_no_os", os_tick, 0);
    wait_for(0, 10, n);
    check("sl_first_os", n, 3);
    wait_for(2, 40, n2);
    check("sl_first_mid", (n < 0 || n2 < 0) ? -1 : n + n2, 24);

    // Sync with a rejected zero load.
    sync = 1'b1; load = 1'b1; div_value = 0;
    @(negedge clk_in);
    sync = 1'b0; load = 1'b0;
    check("sl0_err", load_err, 1);
    check("sl0_div_q", div_q, 2);
    wait_for(0, 10, n);
    check("sl0_first_os", n, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed toggle divider used in the Bluetooth UART RX path.
- Provides a runtime-loadable divisor, a square-wave output, single-cycle strobes, and an oversampling stage with a bit-rate strobe and a mid-bit sample strobe.
- Sits between the system clock and the UART RX/TX bit engines.
- A `sync` input realigns the phase on each RX start-bit edge.

Parameters:
- CNT_W, 32, width of the prescaler counter and the divisor register.
- DIV_DEFAULT, 5200, divisor loaded at reset; prescale period = DIV_DEFAULT+1 clk_in cycles.
- OS_RATIO, 16, oversample ticks per bit; legal range 2..256, must be even.
- OS_W, 8, oversample counter width; must satisfy 2^OS_W >= OS_RATIO.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = counters run; 0 = counters and outputs hold, strobes forced 0.
- load  in  1  single-cycle request to load div_value.
- div_value  in  CNT_W  new divisor.
- sync  in  1  phase realign; clears both counters.
- div_q  out  CNT_W  divisor currently in use.
- clk_div  out  1  square wave, toggles on every prescale terminal count.
- os_tick  out  1  one-cycle strobe on every prescale terminal count.
- bit_tick  out  1  one-cycle strobe every OS_RATIO os_ticks.
- mid_tick  out  1  one-cycle strobe at the OS_RATIO/2 point of each bit.
- load_err  out  1  sticky; set when a load of value 0 is rejected.

Behaviour:
- Reset (reset=0, async):
  - count=0, os_cnt=0, div_q=DIV_DEFAULT.
  - clk_div=0, os_tick=0, bit_tick=0, mid_tick=0, load_err=0.
  - All outputs are registered; no output is combinational from inputs.
- Prescaler, when enable=1 and neither sync nor a load occurs this cycle:
  - If count==div_q: count<=0, clk_div<=~clk_div, os_tick<=1 for one cycle.
  - Otherwise count<=count+1, os_tick<=0.
  - Period = div_q+1 cycles; clk_div period = 2*(div_q+1) cycles.
- Oversample counter, advanced only on a terminal-count cycle:
  - If os_cnt==OS_RATIO-1: os_cnt<=0 and bit_tick<=1.
  - Otherwise os_cnt<=os_cnt+1.
  - mid_tick<=1 when the terminal-count cycle takes os_cnt from OS_RATIO/2-1 to OS_RATIO/2.
  - bit_tick and mid_tick are coincident with the os_tick of the same terminal count; both are 0 on all other cycles.
  - bit_tick and mid_tick are never asserted in the same cycle.
- Priority, highest first: reset, sync, load, enable/count.
- sync=1:
  - count<=0, os_cnt<=0; clk_div and div_q unchanged.
  - All strobes 0 that cycle, even if count==div_q.
  - Effect: the first mid_tick arrives (OS_RATIO/2)*(div_q+1) cycles after sync deasserts.
- load=1 and div_value!=0, no sync:
  - div_q<=div_value, count<=0; os_cnt and clk_div hold; strobes 0 that cycle.
  - The new period applies from the next cycle.
- load=1 and div_value==0:
  - Rejected: div_q, count and os_cnt unchanged, and counting continues normally that cycle.
  - load_err<=1; cleared only by reset.
- sync and load together:
  - sync wins the counter clear.
  - The load is still accepted (div_q updated, or load_err set).
- enable=0:
  - Counters and clk_div hold, strobes 0.
  - load and sync still act.
- Wrap-around: count never exceeds div_q. A load of a value below the current count is safe because the load clears count.
- Reset mid-operation: all state returns to reset values immediately; counting restarts from 0 on the first enabled cycle after release.
- Minimum divisor 1: os_tick every 2 cycles; clk_div period 4 cycles.

Test Plan:
- Reset release, then load div_value=3, enable=1, OS_RATIO=16:
  - os_tick every 4 cycles; clk_div period 8 cycles.
  - bit_tick every 64 cycles; mid_tick 32 cycles after each bit_tick.
- Default divisor, no load: first os_tick 5201 cycles after enable; clk_div high for 5201 cycles, then low for 5201.
- With div_q=3, pulse sync at count=2, os_cnt=5:
  - No strobe that cycle.
  - Next os_tick 4 cycles later; first mid_tick 32 cycles after sync.
- Load div_value=0:
  - load_err=1, div_q unchanged, os_tick cadence unchanged.
  - Load 7: period becomes 8 cycles starting from count=0.
- enable=0 for 10 cycles mid-count: count and clk_div frozen, no strobes; the period resumes where it stopped.
- Assert reset (0) asynchronously mid-period:
  - All outputs 0 and div_q=5200 with no clock edge.
  - sync and load asserted together afterwards: counters cleared and div_q updated.
